pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It merges the hazard sources into the shared `stall[3:0]` vector that every pipeline register (if_id, id_exe, exe_mem, mem_wb) consumes:
- AXI fetch busy
- load-use
- multi-cycle divide
- AXI data busy

It also drives the pipeline-wide `flush`/redirect on exceptions and ERET. It owns the divider cycle counter and the post-flush drain of an in-flight instruction fetch.

## Interface
Parameters:
- DIV_CYCLES, 33, cycles a divide occupies EXE after acceptance (≥2)
- EXC_VECTOR, 32'hBFC00380, redirect PC for exceptions

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_req_busy  in  1  fetch AXI transaction outstanding
- data_req_busy  in  1  MEM-stage AXI load/store outstanding
- id_load_use  in  1  ID operand depends on load currently in EXE
- exe_div_start  in  1  DIV/DIVU present in EXE, level, held while EXE frozen
- exception_valid  in  1  MEM-stage exception committed this cycle
- eret_valid  in  1  MEM-stage ERET committed this cycle
- cp0_epc  in  32  EPC value for ERET
- stall  out  4  bit0 inst, bit1 id, bit2 exe, bit3 data
- flush  out  1  clear all pipeline registers at next edge
- flush_pc  out  32  redirect target, valid when flush=1
- div_done  out  1  divider result valid, EXE may capture
- div_abort  out  1  cancel running divide
- discard_inst  out  1  drop next fetch response

## Operation
- States: IDLE, DIV, DRAIN. Registers: state, 6-bit cnt.
- flush = exception_valid | eret_valid (combinational).
- flush_pc = EXC_VECTOR if exception_valid, else cp0_epc. Exception wins when both are set.
- Stall priority in non-flush cycles, first match wins:
  - data_req_busy → 4'b1111
  - state==DIV and cnt≠0 → 4'b0111
  - id_load_use → 4'b0011
  - inst_req_busy or state==DRAIN → 4'b0001
  - else → 4'b0000
- In a flush cycle, stall=4'b0000 regardless of inputs.
- IDLE:
  - exe_div_start=1, data_req_busy=0, flush=0 → DIV, cnt←DIV_CYCLES-1.
  - Otherwise exe_div_start is ignored.
- DIV:
  - cnt decrements every cycle while nonzero, including data-stalled cycles.
  - cnt==0 → div_done=1 (combinational). If data_req_busy=0 → IDLE. Otherwise stay in DIV with cnt=0 and div_done held until data_req_busy falls.
- DRAIN:
  - discard_inst=1.
  - inst_req_busy=0 → IDLE.
- flush in any state:
  - If state==DIV → div_abort=1 that cycle.
  - cnt←0.
  - Next state is DRAIN if inst_req_busy=1, else IDLE.
  - Applies in DRAIN too: stays in DRAIN while busy.
- Outputs are 0 unless their condition is stated above.

## Timing
- Reset (rst=1 at edge): state=IDLE, cnt=0. All outputs 0 in the following cycle, assuming inputs are 0.
- stall, flush, flush_pc, div_done, div_abort and discard_inst are combinational from inputs and state, and take effect at the same edge.
- Divide latency: acceptance edge plus DIV_CYCLES-1 cycles of stall[2]=1. div_done is asserted in cycle DIV_CYCLES after acceptance.
- The exception cycle always has stall=0, so the redirect PC is loaded on that same edge.
- A fetch response arriving while in DRAIN is discarded. The first response accepted is the one for flush_pc.

## Test plan
- Reset: rst=1 for 2 cycles with all inputs 1 → after release with inputs 0, stall=0000, flush=0, state IDLE.
- Divide (DIV_CYCLES=33): exe_div_start held → stall=0111 for 32 cycles, div_done=1 in cycle 33, stall=0000 in cycle 34. With data_req_busy=1 during cycles 10-12 → stall=1111 there and div_done still at cycle 33.
- Priority: id_load_use=1 and inst_req_busy=1 → 0011; add data_req_busy=1 → 1111; drop both busy inputs → 0011.
- Exception mid-divide: exception_valid at cycle 5 of a divide with inst_req_busy=1 → flush=1, flush_pc=BFC00380, div_abort=1, stall=0000. Next cycles give stall=0001 and discard_inst=1 until inst_req_busy falls, then IDLE.
- ERET: eret_valid=1, cp0_epc=0x80001234 → flush_pc=0x80001234. With exception_valid also 1 → flush_pc=BFC00380.
- Divide blocked: exe_div_start=1 with data_req_busy=1 for 3 cycles → no counting (stall=1111). Acceptance occurs at the first edge with data_req_busy=0, and div_done follows 33 cycles later.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage MIPS pipeline.
// Merges fetch, load-use, divide and data hazards into one stall vector and drives exception/ERET redirects.
module pipeline_ctrl #(
    parameter int unsigned    DIV_CYCLES = 33,
    parameter logic [31:0]    EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_busy,
    input  logic        data_req_busy,
    input  logic        id_load_use,
    input  logic        exe_div_start,
    input  logic        exception_valid,
    input  logic        eret_valid,
    input  logic [31:0] cp0_epc,
    output logic [3:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        div_done,
    output logic        div_abort,
    output logic        discard_inst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);

    state_t     state;
    logic [5:0] cnt;
    logic       flush_now;
    logic       div_running;

    assign flush_now   = exception_valid | eret_valid;
    assign div_running = (state == DIV) && (cnt != '0);

    always_comb begin
        flush        = flush_now;
        flush_pc     = '0;
        stall        = '0;
        div_done     = (state == DIV) && (cnt == '0);
        div_abort    = flush_now && (state == DIV);
        discard_inst = (state == DRAIN);

        if (exception_valid) begin
            flush_pc = EXC_VECTOR;
        end else if (eret_valid) begin
            flush_pc = cp0_epc;
        end

        // A flush cycle never stalls, so the redirect PC loads on the same edge.
        if (!flush_now) begin
            if (data_req_busy) begin
                stall = 4'b1111;
            end else if (div_running) begin
                stall = 4'b0111;
            end else if (id_load_use) begin
                stall = 4'b0011;
            end else if (inst_req_busy || (state == DRAIN)) begin
                stall = 4'b0001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (flush_now) begin
            // An outstanding fetch belongs to the squashed path and must be drained.
            cnt   <= '0;
            state <= inst_req_busy ? DRAIN : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (exe_div_start && !data_req_busy) begin
                        state <= DIV;
                        cnt   <= CNT_INIT;
                    end
                end
                DIV: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 6'd1;
                    end else if (!data_req_busy) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!inst_req_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus queues expected outputs, a monitor compares each cycle.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_busy, data_req_busy, id_load_use, exe_div_start;
    logic        exception_valid, eret_valid;
    logic [31:0] cp0_epc;
    logic [3:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        div_done, div_abort, discard_inst;

    localparam logic [31:0] EXC = 32'hBFC00380;

    typedef struct {
        string       name;
        logic [39:0] exp;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    failures = 0;

    pipeline_ctrl #(.DIV_CYCLES(33), .EXC_VECTOR(32'hBFC00380)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req_busy  (inst_req_busy),
        .data_req_busy  (data_req_busy),
        .id_load_use    (id_load_use),
        .exe_div_start  (exe_div_start),
        .exception_valid(exception_valid),
        .eret_valid     (eret_valid),
        .cp0_epc        (cp0_epc),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .div_done       (div_done),
        .div_abort      (div_abort),
        .discard_inst   (discard_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] pk(input logic [3:0] s, input logic f, input logic [31:0] p,
                                       input logic dd, input logic da, input logic di);
        return {s, f, p, dd, da, di};
    endfunction

    // Monitor: every output cycle with a queued expectation is compared at negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [39:0] act;
            it  = q.pop_front();
            act = {stall, flush, flush_pc, div_done, div_abort, discard_inst};
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: got stall=%b flush=%b pc=%h done=%b abort=%b discard=%b, expected stall=%b flush=%b pc=%h done=%b abort=%b discard=%b",
                         it.name, act[39:36], act[35], act[34:3], act[2], act[1], act[0],
                         it.exp[39:36], it.exp[35], it.exp[34:3], it.exp[2], it.exp[1], it.exp[0]);
            end
        end
    end

    task automatic cyc(input string nm, input logic [3:0] s, input logic f, input logic [31:0] p,
                       input logic dd, input logic da, input logic di);
        item_t it;
        it.name = nm;
        it.exp  = pk(s, f, p, dd, da, di);
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        inst_req_busy = 0; data_req_busy = 0; id_load_use = 0; exe_div_start = 0;
        exception_valid = 0; eret_valid = 0; cp0_epc = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        inst_req_busy = 1; data_req_busy = 1; id_load_use = 1; exe_div_start = 1;
        exception_valid = 1; eret_valid = 1; cp0_epc = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        zero_inputs();
        cyc("reset", 4'b0000, 0, '0, 0, 0, 0);
        cyc("reset_idle", 4'b0000, 0, '0, 0, 0, 0);

        // Plain divide: accept, 32 stalled cycles, done on cycle 33.
        exe_div_start = 1;
        cyc("div_accept", 4'b0000, 0, '0, 0, 0, 0);
        for (int c = 1; c <= 32; c++) cyc("div_count", 4'b0111, 0, '0, 0, 0, 0);
        cyc("div_done", 4'b0000, 0, '0, 1, 0, 0);
        exe_div_start = 0;
        cyc("div_after", 4'b0000, 0, '0, 0, 0, 0);

        // Divide with data busy in cycles 10-12: counting continues underneath.
        exe_div_start = 1;
        cyc("divb_accept", 4'b0000, 0, '0, 0, 0, 0);
        for (int c = 1; c <= 32; c++) begin
            data_req_busy = (c >= 10 && c <= 12);
            if (data_req_busy) cyc("divb_data", 4'b1111, 0, '0, 0, 0, 0);
            else cyc("divb_count", 4'b0111, 0, '0, 0, 0, 0);
        end
        data_req_busy = 0;
        cyc("divb_done", 4'b0000, 0, '0, 1, 0, 0);
        exe_div_start = 0;
        cyc("divb_after", 4'b0000, 0, '0, 0, 0, 0);

        // Priority ordering.
        id_load_use = 1; inst_req_busy = 1;
        cyc("prio_lu_ib", 4'b0011, 0, '0, 0, 0, 0);
        data_req_busy = 1;
        cyc("prio_data", 4'b1111, 0, '0, 0, 0, 0);
        data_req_busy = 0; inst_req_busy = 0;
        cyc("prio_lu", 4'b0011, 0, '0, 0, 0, 0);
        id_load_use = 0; inst_req_busy = 1;
        cyc("prio_ib", 4'b0001, 0, '0, 0, 0, 0);
        inst_req_busy = 0;
        cyc("prio_none", 4'b0000, 0, '0, 0, 0, 0);

        // Exception at cycle 5 of a divide with fetch outstanding.
        exe_div_start = 1;
        cyc("exc_accept", 4'b0000, 0, '0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) cyc("exc_div", 4'b0111, 0, '0, 0, 0, 0);
        exe_div_start = 0; exception_valid = 1; inst_req_busy = 1;
        cyc("exc_flush", 4'b0000, 1, EXC, 0, 1, 0);
        exception_valid = 0;
        for (int c = 0; c < 3; c++) cyc("exc_drain", 4'b0001, 0, '0, 0, 0, 1);
        inst_req_busy = 0;
        cyc("exc_drain_last", 4'b0001, 0, '0, 0, 0, 1);
        cyc("exc_idle", 4'b0000, 0, '0, 0, 0, 0);

        // ERET redirect, then exception taking precedence.
        eret_valid = 1; cp0_epc = 32'h80001234; id_load_use = 1;
        cyc("eret", 4'b0000, 1, 32'h80001234, 0, 0, 0);
        exception_valid = 1;
        cyc("eret_exc", 4'b0000, 1, EXC, 0, 0, 0);
        zero_inputs();
        cyc("eret_after", 4'b0000, 0, '0, 0, 0, 0);

        // Divide blocked by data busy, then done held while data busy at the end.
        exe_div_start = 1; data_req_busy = 1;
        for (int c = 0; c < 3; c++) cyc("blk_wait", 4'b1111, 0, '0, 0, 0, 0);
        data_req_busy = 0;
        cyc("blk_accept", 4'b0000, 0, '0, 0, 0, 0);
        for (int c = 1; c <= 32; c++) cyc("blk_count", 4'b0111, 0, '0, 0, 0, 0);
        data_req_busy = 1;
        cyc("blk_done_busy", 4'b1111, 0, '0, 1, 0, 0);
        cyc("blk_done_hold", 4'b1111, 0, '0, 1, 0, 0);
        data_req_busy = 0;
        cyc("blk_done", 4'b0000, 0, '0, 1, 0, 0);
        exe_div_start = 0;
        cyc("blk_after", 4'b0000, 0, '0, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
